// File: rtl/rf_packet_framer.sv
// ---------------------------------------------------------------------------
// rf_packet_framer
//
// Purpose:
//   Pulls bytes from an upstream FIFO and sends them to a byte-wide RF/UART
//   transmitter as length-prefixed packets. A packet is started either when a
//   full payload of MAX_PAYLOAD bytes is waiting, or when a partial payload
//   has been sitting untouched for IDLE_TIMEOUT cycles. Every byte leaves
//   through a valid/ready handshake.
//
//   The framer cannot see the FIFO's internal count. It keeps its own
//   occupancy count by watching the upstream write strobe and its own pops.
//
// Optional feature:
//   RF_PACKET_FRAMER_CHECKSUM_EN
//     When defined, each packet ends with one extra byte. That byte is the
//     XOR of the header and every payload byte.
//     When undefined, there is no checksum state and no checksum register.
//
// Parameters:
//   WIDTH        data width of the FIFO and of the transmitter
//   DEPTH        depth of the upstream FIFO (the occupancy count saturates here)
//   MAX_PAYLOAD  largest payload per packet, 1..min(DEPTH, 2^WIDTH-1)
//   IDLE_TIMEOUT idle cycles before a partial payload is flushed, >= 1
//
// Ports:
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset
//   enable         allows new packets to start; a packet in flight always completes
//   fifo_write_ins upstream write strobe (monitored only)
//   fifo_full      upstream full flag; a write while full is not counted
//   fifo_data_in   FIFO head data, valid the cycle after a pop
//   fifo_read_ins  one-cycle pop strobe to the FIFO
//   tx_data        byte to the transmitter
//   tx_valid       tx_data is valid
//   tx_ready       transmitter takes the byte when tx_valid && tx_ready
//   busy           high in any state other than IDLE
//   packet_done    one-cycle pulse at the end of each packet
// ---------------------------------------------------------------------------
module rf_packet_framer #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 512,
    parameter int MAX_PAYLOAD  = 58,
    parameter int IDLE_TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             fifo_write_ins,
    input  logic             fifo_full,
    input  logic [WIDTH-1:0] fifo_data_in,
    output logic             fifo_read_ins,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             packet_done
);

    localparam int OCC_W  = $clog2(DEPTH + 1);
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [OCC_W-1:0]  DEPTH_V   = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0]  MAX_V     = OCC_W'(MAX_PAYLOAD);
    localparam logic [OCC_W-1:0]  OCC_ONE   = OCC_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [WIDTH-1:0]  BYTE_ONE  = WIDTH'(1);

`ifdef RF_PACKET_FRAMER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_POP    = 3'd2,
        ST_LOAD   = 3'd3,
        ST_SEND   = 3'd4,
        ST_CKSUM  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_POP    = 3'd2,
        ST_LOAD   = 3'd3,
        ST_SEND   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;
`endif

    state_t state;
    state_t next_state;

    logic [OCC_W-1:0]  occupancy;
    logic [IDLE_W-1:0] idle_count;
    logic [WIDTH-1:0]  len;
    logic [WIDTH-1:0]  remaining;
    logic [WIDTH-1:0]  payload_reg;
`ifdef RF_PACKET_FRAMER_CHECKSUM_EN
    logic [WIDTH-1:0]  checksum;
`endif

    logic             write_accept;
    logic             start_ok;
    logic [OCC_W-1:0] start_len;

    // A write counts only if the FIFO could take it.
    // A packet starts for one of two reasons:
    //   - a full payload is queued, or
    //   - a partial payload has gone stale.
    // start_len is the payload length latched at that moment.
    always_comb begin
        write_accept = fifo_write_ins && !fifo_full;
        start_ok     = enable && ((occupancy >= MAX_V) ||
                                  ((occupancy != '0) && (idle_count == IDLE_MAX)));
        start_len    = (occupancy >= MAX_V) ? MAX_V : occupancy;
    end

    // Shadow occupancy of the upstream FIFO.
    // A push and a pop in the same cycle cancel out.
    // The count saturates at both ends, so a monitoring glitch cannot wrap it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else if (write_accept && !fifo_read_ins) begin
            if (occupancy < DEPTH_V) begin
                occupancy <= occupancy + OCC_ONE;
            end
        end else if (fifo_read_ins && !write_accept) begin
            if (occupancy != '0) begin
                occupancy <= occupancy - OCC_ONE;
            end
        end
    end

    // Idle counter: cycles since the last accepted write.
    // It is held at zero while the FIFO is empty, so the timeout only
    // measures how long queued data has been waiting. It saturates so that
    // the timeout condition stays true until a packet takes the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_count <= '0;
        end else if (write_accept || (occupancy == '0)) begin
            idle_count <= '0;
        end else if (idle_count != IDLE_MAX) begin
            idle_count <= idle_count + IDLE_ONE;
        end
    end

    // State register.
    // Reset returns straight to IDLE, so a packet in flight is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control outputs.
    // Each payload byte takes three steps:
    //   POP  - pop the FIFO,
    //   LOAD - capture the head data the FIFO presents one cycle later,
    //   SEND - offer the byte to the transmitter.
    // The last handshake in SEND (remaining == 1) ends the payload.
    // enable is only consulted in IDLE, so dropping it never aborts a packet.
    always_comb begin
        next_state    = state;
        tx_valid      = 1'b0;
        fifo_read_ins = 1'b0;
        packet_done   = 1'b0;
        busy          = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    next_state = ST_HEADER;
                end
            end
            ST_HEADER: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    next_state = ST_POP;
                end
            end
            ST_POP: begin
                fifo_read_ins = 1'b1;
                next_state    = ST_LOAD;
            end
            ST_LOAD: begin
                next_state = ST_SEND;
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    if (remaining != BYTE_ONE) begin
                        next_state = ST_POP;
                    end else begin
`ifdef RF_PACKET_FRAMER_CHECKSUM_EN
                        next_state = ST_CKSUM;
`else
                        next_state = ST_DONE;
`endif
                    end
                end
            end
`ifdef RF_PACKET_FRAMER_CHECKSUM_EN
            ST_CKSUM: begin
                tx_valid = 1'b1;
                if (tx_ready) begin
                    next_state = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                packet_done = 1'b1;
                next_state  = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Packet datapath.
    // On start, latch the length and the payload countdown.
    // In LOAD, capture the FIFO head data.
    // In SEND, each handshake moves the countdown on.
    // The header (and the checksum, when enabled) is seeded with the length,
    // so the final XOR already covers the header byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len         <= '0;
            remaining   <= '0;
            payload_reg <= '0;
`ifdef RF_PACKET_FRAMER_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        len       <= WIDTH'(start_len);
                        remaining <= WIDTH'(start_len);
`ifdef RF_PACKET_FRAMER_CHECKSUM_EN
                        checksum  <= WIDTH'(start_len);
`endif
                    end
                end
                ST_LOAD: begin
                    payload_reg <= fifo_data_in;
`ifdef RF_PACKET_FRAMER_CHECKSUM_EN
                    checksum    <= checksum ^ fifo_data_in;
`endif
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        remaining <= remaining - BYTE_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Transmit byte select:
    //   HEADER - the latched length,
    //   CKSUM  - the running XOR,
    //   otherwise - the last captured payload byte.
    // Every source is a register, so tx_data cannot change while a handshake
    // is stalled.
    always_comb begin
        tx_data = payload_reg;
        case (state)
            ST_HEADER: tx_data = len;
`ifdef RF_PACKET_FRAMER_CHECKSUM_EN
            ST_CKSUM:  tx_data = checksum;
`endif
            default:   tx_data = payload_reg;
        endcase
    end

endmodule

// File: tb/tb_rf_packet_framer.sv
// ---------------------------------------------------------------------------
// tb_rf_packet_framer
//
// Self-checking bench for rf_packet_framer.
//
// A queue models the upstream FIFO. The expected transmit stream comes from
// a packet model: the written bytes are cut into chunks of at most
// MAX_PAYLOAD. Each chunk is sent as
//   - a length byte,
//   - the chunk bytes,
//   - an XOR byte, when RF_PACKET_FRAMER_CHECKSUM_EN is defined.
// ---------------------------------------------------------------------------
module tb_rf_packet_framer;

    localparam int WIDTH        = 8;
    localparam int DEPTH        = 512;
    localparam int MAX_PAYLOAD  = 58;
    localparam int IDLE_TIMEOUT = 1000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             fifo_write_ins;
    logic             fifo_full;
    logic [WIDTH-1:0] fifo_data_in;
    logic             fifo_read_ins;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic             packet_done;

    // Free-running clock.
    always #5 clk = ~clk;

    rf_packet_framer #(
        .WIDTH        (WIDTH),
        .DEPTH        (DEPTH),
        .MAX_PAYLOAD  (MAX_PAYLOAD),
        .IDLE_TIMEOUT (IDLE_TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .fifo_write_ins (fifo_write_ins),
        .fifo_full      (fifo_full),
        .fifo_data_in   (fifo_data_in),
        .fifo_read_ins  (fifo_read_ins),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .busy           (busy),
        .packet_done    (packet_done)
    );

    logic [7:0] fifo_q[$];
    logic [7:0] burst_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         fifo_count = 0;
    logic [7:0] wr_byte;
    logic       force_full;
    logic       flush_fifo;
    logic       rand_ready;

    int total = 0;
    int bad   = 0;

    int pop_cnt   = 0;
    int done_cnt  = 0;
    int busy_cnt  = 0;
    int viol_cnt  = 0;

    int obs_base    = 0;
    int pop_base    = 0;
    int done_base   = 0;
    int exp_packets = 0;
    int exp_payload = 0;

    assign fifo_full = force_full || (fifo_count >= DEPTH);

    // Upstream FIFO model.
    // A pop presents the head byte on the following cycle.
    always @(posedge clk) begin
        if (flush_fifo) begin
            fifo_q.delete();
            fifo_count <= 0;
        end else begin
            if (fifo_read_ins && (fifo_q.size() > 0)) begin
                fifo_data_in <= fifo_q.pop_front();
            end
            if (fifo_write_ins && !fifo_full) begin
                fifo_q.push_back(wr_byte);
            end
            fifo_count <= fifo_q.size();
        end
    end

    // Monitor, sampled mid-cycle.
    // Records every handshaked byte and counts pops, done pulses and busy
    // cycles. Also flags breaks of the valid/pop rules:
    //   - tx_valid while popping, in DONE, or in IDLE,
    //   - a pop from an empty FIFO.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid && tx_ready) begin
                obs_q.push_back(tx_data);
            end
            if (fifo_read_ins) begin
                pop_cnt <= pop_cnt + 1;
            end
            if (packet_done) begin
                done_cnt <= done_cnt + 1;
            end
            if (busy) begin
                busy_cnt <= busy_cnt + 1;
            end
            if (tx_valid && (fifo_read_ins || packet_done || !busy)) begin
                viol_cnt <= viol_cnt + 1;
            end
            if (fifo_read_ins && (fifo_q.size() == 0)) begin
                viol_cnt <= viol_cnt + 1;
            end
        end
    end

    // Watchdog so the run always ends, even if the DUT locks up.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) begin
            tx_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Push n bytes into the FIFO, one per cycle.
    // The bytes are an incrementing sequence from 'first' when seq is set,
    // otherwise random. Each byte is also recorded for the model.
    task automatic apply_stimulus(input int n, input bit seq, input logic [7:0] first);
        for (int i = 0; i < n; i++) begin
            wr_byte = seq ? 8'(first + 8'(i)) : 8'($urandom_range(0, 255));
            burst_q.push_back(wr_byte);
            fifo_write_ins = 1'b1;
            tick();
        end
        fifo_write_ins = 1'b0;
    endtask

    // Packet model.
    // Written data is cut into chunks of at most MAX_PAYLOAD. Each chunk
    // becomes a length byte followed by its bytes, plus an XOR byte when the
    // checksum is enabled.
    function automatic void build_expected();
        while (burst_q.size() > 0) begin
            int n = (burst_q.size() >= MAX_PAYLOAD) ? MAX_PAYLOAD : burst_q.size();
`ifdef RF_PACKET_FRAMER_CHECKSUM_EN
            logic [7:0] x = 8'(n);
`endif
            exp_q.push_back(8'(n));
            exp_packets++;
            exp_payload += n;
            for (int i = 0; i < n; i++) begin
                logic [7:0] b = burst_q.pop_front();
`ifdef RF_PACKET_FRAMER_CHECKSUM_EN
                x = x ^ b;
`endif
                exp_q.push_back(b);
            end
`ifdef RF_PACKET_FRAMER_CHECKSUM_EN
            exp_q.push_back(x);
`endif
        end
    endfunction

    task automatic begin_scenario();
        obs_base    = obs_q.size();
        pop_base    = pop_cnt;
        done_base   = done_cnt;
        exp_packets = 0;
        exp_payload = 0;
        exp_q.delete();
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int k = 0;
        while ((done_cnt < target) && (k < budget)) begin
            tick();
            k++;
        end
        check_output({tag, "_done_in_time"}, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic check_scenario(input string tag);
        int n_obs = obs_q.size() - obs_base;
        check_output({tag, "_stream_len"}, n_obs, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < n_obs) begin
                check_output($sformatf("%s_byte%0d", tag, i), obs_q[obs_base + i], exp_q[i]);
            end
        end
        check_output({tag, "_pops"}, pop_cnt - pop_base, exp_payload);
        check_output({tag, "_packets"}, done_cnt - done_base, exp_packets);
        check_output({tag, "_idle_after"}, busy, 1'b0);
    endtask

    // Directed sequence of scenarios.
    initial begin
        int         lat;
        int         k;
        int         busy0;
        int         p0;
        logic [7:0] d0;
        bit         stable;

        rst_n          = 1'b0;
        enable         = 1'b0;
        fifo_write_ins = 1'b0;
        tx_ready       = 1'b0;
        wr_byte        = 8'h00;
        force_full     = 1'b0;
        flush_fifo     = 1'b0;
        rand_ready     = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_tx_valid", tx_valid, 1'b0);
        check_output("reset_tx_data", tx_data, 8'h00);
        check_output("reset_read", fifo_read_ins, 1'b0);
        check_output("reset_busy", busy, 1'b0);
        check_output("reset_done", packet_done, 1'b0);
        rst_n    = 1'b1;
        tx_ready = 1'b1;
        enable   = 1'b1;
        tick();

        // Full-size packet from the incrementing sequence 0x01..0x3A.
        $display("[TB] full packet of 58 sequential bytes");
        begin_scenario();
        apply_stimulus(58, 1'b1, 8'h01);
        build_expected();
        wait_done("seq58", done_base + exp_packets, 1000);
        repeat (3) tick();
        check_scenario("seq58");

        // Partial packet, flushed only after the idle timeout.
        $display("[TB] partial packet flushed by timeout");
        begin_scenario();
        apply_stimulus(3, 1'b1, 8'hA0);
        lat = 0;
        while (!busy && (lat < 1200)) begin
            tick();
            lat++;
        end
        check_output("timeout_latency", lat, IDLE_TIMEOUT + 1);
        build_expected();
        wait_done("partial3", done_base + exp_packets, 200);
        repeat (3) tick();
        check_scenario("partial3");

        // Stall the transmitter for 20 cycles in the middle of SEND.
        $display("[TB] transmitter stall during payload");
        begin_scenario();
        apply_stimulus(58, 1'b0, 8'h00);
        build_expected();
        k = 0;
        while (!((pop_cnt - pop_base >= 5) && tx_valid) && (k < 1000)) begin
            tick();
            k++;
        end
        check_output("stall_reached", 32'(k < 1000), 32'd1);
        tx_ready = 1'b0;
        d0       = tx_data;
        p0       = pop_cnt;
        stable   = 1'b1;
        repeat (20) begin
            tick();
            if (!tx_valid || (tx_data !== d0)) begin
                stable = 1'b0;
            end
        end
        check_output("stall_stable", stable, 1'b1);
        check_output("stall_no_pop", pop_cnt, p0);
        tx_ready = 1'b1;
        wait_done("stall", done_base + exp_packets, 1000);
        repeat (3) tick();
        check_scenario("stall");

        // 120 continuous bytes with a random ready pattern.
        // Pops overlap with ongoing writes.
        $display("[TB] 120 byte burst with random ready");
        begin_scenario();
        rand_ready = 1'b1;
        apply_stimulus(120, 1'b0, 8'h00);
        build_expected();
        wait_done("burst120", done_base + exp_packets, 6000);
        rand_ready = 1'b0;
        tx_ready   = 1'b1;
        repeat (3) tick();
        check_scenario("burst120");

        // With enable low, nothing starts.
        // Dropping enable mid-packet still lets the packet complete.
        $display("[TB] enable gating");
        begin_scenario();
        enable = 1'b0;
        apply_stimulus(100, 1'b0, 8'h00);
        build_expected();
        busy0 = busy_cnt;
        repeat (1100) tick();
        check_output("enable_low_no_start", busy_cnt - busy0, 0);
        enable = 1'b1;
        k = 0;
        while (!busy && (k < 10)) begin
            tick();
            k++;
        end
        check_output("enable_start", busy, 1'b1);
        enable = 1'b0;
        wait_done("enable_drop", done_base + 1, 1000);
        repeat (1100) tick();
        check_output("enable_low_hold", done_cnt - done_base, 1);
        enable = 1'b1;
        wait_done("enable_flush", done_base + 2, 1000);
        repeat (3) tick();
        check_scenario("enable");

        // Reset in the middle of SEND.
        // Outputs must clear at once, and the packet must not resume.
        $display("[TB] reset during payload");
        begin_scenario();
        apply_stimulus(58, 1'b0, 8'h00);
        burst_q.delete();
        k = 0;
        while (!((pop_cnt - pop_base >= 3) && tx_valid) && (k < 1000)) begin
            tick();
            k++;
        end
        tx_ready = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_output("rst_mid_tx_valid", tx_valid, 1'b0);
        check_output("rst_mid_tx_data", tx_data, 8'h00);
        check_output("rst_mid_read", fifo_read_ins, 1'b0);
        check_output("rst_mid_busy", busy, 1'b0);
        check_output("rst_mid_done", packet_done, 1'b0);
        flush_fifo = 1'b1;
        tick();
        tick();
        flush_fifo = 1'b0;
        rst_n      = 1'b1;
        tx_ready   = 1'b1;
        begin_scenario();
        busy0 = busy_cnt;
        repeat (1100) tick();
        check_output("rst_no_resume_busy", busy_cnt - busy0, 0);
        check_output("rst_no_resume_bytes", obs_q.size() - obs_base, 0);
        check_output("rst_no_resume_done", done_cnt - done_base, 0);

        // Normal operation resumes after the reset.
        begin_scenario();
        apply_stimulus(3, 1'b1, 8'h10);
        build_expected();
        wait_done("post_reset", done_base + exp_packets, 1300);
        repeat (3) tick();
        check_scenario("post_reset");

        // Write strobes while the FIFO reports full must not be counted.
        $display("[TB] writes ignored while full");
        begin_scenario();
        force_full = 1'b1;
        repeat (100) begin
            wr_byte        = 8'($urandom_range(0, 255));
            fifo_write_ins = 1'b1;
            tick();
        end
        fifo_write_ins = 1'b0;
        force_full     = 1'b0;
        busy0 = busy_cnt;
        repeat (1100) tick();
        check_output("full_no_start", busy_cnt - busy0, 0);
        check_output("full_no_done", done_cnt - done_base, 0);

        check_output("protocol_rules", viol_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
